instr_stream_encoder: RTL and testbench

//  Inverse of the opcode decoder: accepts one RV32I instruction request per handshake
//  (opcode[6:2] class plus rd/rs1/rs2/funct3/funct7b5/imm fields).

---
 rtl/instr_stream_encoder_if.sv | 36 +++
 rtl/instr_stream_encoder.sv | 188 ++++++++++++++++++
 tb/tb_instr_stream_encoder.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_stream_encoder_if.sv
// Request channel for the instruction stream encoder.
// Purpose : carries one RV32I instruction request (class code plus operand
//           fields) from a program source to the encoder using valid/ready.
// Signals :
//   req_valid    source -> encoder  request present
//   req_ready    encoder -> source  request accepted on clk edge when valid & ready
//   req_opcode   source -> encoder  instr[6:2] class code
//   req_rd       source -> encoder  destination register
//   req_rs1      source -> encoder  source register 1
//   req_rs2      source -> encoder  source register 2
//   req_funct3   source -> encoder  funct3
//   req_funct7b5 source -> encoder  instr[30] (SUB/SRA/SRAI)
//   req_imm      source -> encoder  immediate as seen by the ALU (U-type already <<12)
interface instr_stream_encoder_if;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_opcode;
    logic [4:0]  req_rd;
    logic [4:0]  req_rs1;
    logic [4:0]  req_rs2;
    logic [2:0]  req_funct3;
    logic        req_funct7b5;
    logic [31:0] req_imm;

    modport master (
        output req_valid, req_opcode, req_rd, req_rs1, req_rs2,
               req_funct3, req_funct7b5, req_imm,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_opcode, req_rd, req_rs1, req_rs2,
               req_funct3, req_funct7b5, req_imm,
        output req_ready
    );
endinterface

// File: rtl/instr_stream_encoder.sv
// Instruction stream encoder (program loader back end).
// Purpose : accepts one RV32I instruction request per handshake, packs the
//           fields into the 32-bit instruction word for the requested class and
//           writes the words sequentially into instruction memory.
// Ports   :
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   start       in   begin a new program: pointer, count, err and full cleared
//   req         if   request channel (slave side of instr_stream_encoder_if)
//   imem_we     out  one-cycle write strobe
//   imem_addr   out  word address of the write
//   imem_wdata  out  encoded instruction word
//   count       out  words written since start/reset (ADDR_W+1 bits)
//   full        out  memory full, further requests are stalled
//   err         out  sticky: an illegal opcode class was received
module instr_stream_encoder #(
    parameter int ADDR_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    instr_stream_encoder_if.slave req,
    output logic                 imem_we,
    output logic [ADDR_W-1:0]    imem_addr,
    output logic [31:0]          imem_wdata,
    output logic [ADDR_W:0]      count,
    output logic                 full,
    output logic                 err
);

    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_OP_IMM = 5'b00100;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_JAL    = 5'b11011;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FMT   = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                full_q, full_d;
    logic                err_q, err_d;
    logic [31:0]         word_q, word_d;
    logic                legal_q, legal_d;

    logic                accept;
    logic [31:0]         enc_word;
    logic                enc_legal;
    logic [6:0]          enc_low;
    logic [2:0]          enc_f3;
    logic [11:0]         enc_imm_i;

    assign accept = req.req_valid & req.req_ready;

    // Field packing for every supported class. Immediate bits the format
    // cannot represent (imm[0] for B/J, high bits for I/S) are simply dropped.
    always_comb begin
        enc_word  = '0;
        enc_legal = 1'b1;
        enc_low   = {req.req_opcode, 2'b11};
        enc_f3    = req.req_funct3;
        enc_imm_i = req.req_imm[11:0];
        case (req.req_opcode)
            OPC_OP: begin
                enc_word = {1'b0, req.req_funct7b5, 5'b00000, req.req_rs2,
                            req.req_rs1, req.req_funct3, req.req_rd, enc_low};
            end
            OPC_LOAD, OPC_OP_IMM, OPC_JALR: begin
                if (req.req_opcode == OPC_JALR) begin
                    enc_f3 = 3'b000;
                end
                // Shift-immediates carry the SRAI selector in bit 30 and a 5-bit shamt.
                if ((req.req_opcode == OPC_OP_IMM) &&
                    ((req.req_funct3 == 3'b001) || (req.req_funct3 == 3'b101))) begin
                    enc_imm_i = {1'b0, req.req_funct7b5, 5'b00000, req.req_imm[4:0]};
                end
                enc_word = {enc_imm_i, req.req_rs1, enc_f3, req.req_rd, enc_low};
            end
            OPC_STORE: begin
                enc_word = {req.req_imm[11:5], req.req_rs2, req.req_rs1,
                            req.req_funct3, req.req_imm[4:0], enc_low};
            end
            OPC_BRANCH: begin
                enc_word = {req.req_imm[12], req.req_imm[10:5], req.req_rs2,
                            req.req_rs1, req.req_funct3, req.req_imm[4:1],
                            req.req_imm[11], enc_low};
            end
            OPC_LUI, OPC_AUIPC: begin
                enc_word = {req.req_imm[31:12], req.req_rd, enc_low};
            end
            OPC_JAL: begin
                enc_word = {req.req_imm[20], req.req_imm[10:1], req.req_imm[11],
                            req.req_imm[19:12], req.req_rd, enc_low};
            end
            default: begin
                enc_legal = 1'b0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
            word_q  <= '0;
            legal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            full_q  <= full_d;
            err_q   <= err_d;
            word_q  <= word_d;
            legal_q <= legal_d;
        end
    end

    // Next state; start overrides everything and aborts an in-flight word.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = FMT;
            FMT:     state_d = legal_q ? WRITE : IDLE;
            WRITE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (start) begin
            state_d = IDLE;
        end
    end

    // Datapath updates. The pointer wraps naturally after the last address;
    // full is what stops a second pass from overwriting the program.
    always_comb begin
        ptr_d   = ptr_q;
        count_d = count_q;
        full_d  = full_q;
        err_d   = err_q;
        word_d  = word_q;
        legal_d = legal_q;
        if (accept) begin
            word_d  = enc_word;
            legal_d = enc_legal;
        end
        if ((state_q == FMT) && !legal_q) begin
            err_d = 1'b1;
        end
        if (state_q == WRITE) begin
            ptr_d   = ptr_q + ADDR_W'(1);
            count_d = count_q + (ADDR_W + 1)'(1);
            if (ptr_q == '1) begin
                full_d = 1'b1;
            end
        end
        if (start) begin
            ptr_d   = '0;
            count_d = '0;
            full_d  = 1'b0;
            err_d   = 1'b0;
        end
    end

    // Outputs. The write strobe is decoded from the state register so an
    // async reset removes it immediately and start suppresses it the same cycle.
    always_comb begin
        imem_we       = (state_q == WRITE) & ~start;
        imem_addr     = ptr_q;
        imem_wdata    = word_q;
        count         = count_q;
        full          = full_q;
        err           = err_q;
        req.req_ready = (state_q == IDLE) & ~full_q & ~start;
    end

endmodule

// File: tb/tb_instr_stream_encoder.sv
// Self-checking bench for instr_stream_encoder: directed program fragments
// followed by randomized requests, with a queue-based scoreboard for writes.
module tb_instr_stream_encoder;

   localparam int ADDR_W = 2;
   localparam int DEPTH  = 1 << ADDR_W;

   typedef struct {
      logic [4:0]  opc;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  f3;
      logic        f7b5;
      logic [31:0] imm;
   } reqT;

   typedef struct {
      int          addr;
      logic [31:0] data;
   } expT;

   logic              clk;
   logic              rst_n;
   logic              start;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic [ADDR_W:0]   count;
   logic              full;
   logic              err;

   instr_stream_encoder_if bus();

   instr_stream_encoder #(.ADDR_W(ADDR_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .req        (bus),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .count      (count),
      .full       (full),
      .err        (err)
   );

   int  checks = 0;
   int  errors = 0;
   expT expQ[$];

   // Reference model of the loader's architectural state.
   int  mPtr   = 0;
   int  mCount = 0;
   bit  mFull  = 0;
   bit  mErr   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
      end
   endtask

   // Reference encoder: builds the word field by field with shifts and masks.
   function automatic logic [31:0] modelEncode(input reqT r, output bit legal);
      logic [31:0] base, rd, rs1, rs2, f3, f7, imm, w, hi;
      base  = (32'(r.opc) << 2) | 32'd3;
      rd    = 32'(r.rd) << 7;
      rs1   = 32'(r.rs1) << 15;
      rs2   = 32'(r.rs2) << 20;
      f3    = 32'(r.f3) << 12;
      f7    = 32'(r.f7b5) << 30;
      imm   = r.imm;
      legal = 1;
      w     = 32'd0;
      case (r.opc)
         5'b01100: w = base | rd | f3 | rs1 | rs2 | f7;
         5'b00000, 5'b00100, 5'b11001: begin
            if (r.opc == 5'b11001) f3 = 32'd0;
            if (r.opc == 5'b00100 && (r.f3 == 3'd1 || r.f3 == 3'd5))
               hi = (imm & 32'h1f) | (32'(r.f7b5) << 10);
            else
               hi = imm & 32'hfff;
            w = base | rd | f3 | rs1 | (hi << 20);
         end
         5'b01000: w = base | ((imm & 32'h1f) << 7) | f3 | rs1 | rs2 | (((imm >> 5) & 32'h7f) << 25);
         5'b11000: w = base | (((imm >> 11) & 32'h1) << 7) | (((imm >> 1) & 32'hf) << 8) | f3 | rs1 | rs2
                       | (((imm >> 5) & 32'h3f) << 25) | (((imm >> 12) & 32'h1) << 31);
         5'b01101, 5'b00101: w = base | rd | (imm & 32'hfffff000);
         5'b11011: w = base | rd | (((imm >> 12) & 32'hff) << 12) | (((imm >> 11) & 32'h1) << 20)
                       | (((imm >> 1) & 32'h3ff) << 21) | (((imm >> 20) & 32'h1) << 31);
         default: legal = 0;
      endcase
      return w;
   endfunction

   function automatic reqT makeReq(input logic [4:0] opc, input logic [4:0] rd, input logic [4:0] rs1,
                                   input logic [4:0] rs2, input logic [2:0] f3, input logic f7b5,
                                   input logic [31:0] imm);
      reqT r;
      r.opc = opc; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2; r.f3 = f3; r.f7b5 = f7b5; r.imm = imm;
      return r;
   endfunction

   function automatic reqT randReq();
      logic [4:0] legalOps[9] = '{5'b00000, 5'b00100, 5'b00101, 5'b01000, 5'b01100,
                                  5'b01101, 5'b11000, 5'b11001, 5'b11011};
      reqT r;
      bit  isLegal;
      r.rd   = 5'($urandom);
      r.rs1  = 5'($urandom);
      r.rs2  = 5'($urandom);
      r.f3   = 3'($urandom);
      r.f7b5 = 1'($urandom);
      r.imm  = $urandom;
      if ($urandom_range(0, 7) == 0) begin
         do begin
            r.opc   = 5'($urandom_range(0, 31));
            isLegal = 0;
            foreach (legalOps[i]) if (legalOps[i] == r.opc) isLegal = 1;
         end while (isLegal);
      end else begin
         r.opc = legalOps[$urandom_range(0, 8)];
      end
      return r;
   endfunction

   task automatic driveReq(input reqT r);
      bus.req_opcode   = r.opc;
      bus.req_rd       = r.rd;
      bus.req_rs1      = r.rs1;
      bus.req_rs2      = r.rs2;
      bus.req_funct3   = r.f3;
      bus.req_funct7b5 = r.f7b5;
      bus.req_imm      = r.imm;
      bus.req_valid    = 1'b1;
   endtask

   // Issue one request, record its expected effect, and wait until the
   // word has been written (or rejected) before checking counters.
   task automatic applyStimulus(input reqT r, input bit useOverride, input logic [31:0] overrideWord,
                                input bit held);
      logic [31:0] w;
      bit          legal;
      int          waitCycles;
      if (!held) begin
         @(negedge clk);
         driveReq(r);
      end
      waitCycles = 0;
      while (bus.req_ready !== 1'b1 && waitCycles < 40) begin
         @(negedge clk);
         waitCycles++;
      end
      if (bus.req_ready !== 1'b1) begin
         checks++;
         errors++;
         $display("[TB] FAIL accept_timeout actual=ready_low required=ready_high");
         bus.req_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      w = modelEncode(r, legal);
      if (useOverride) w = overrideWord;
      if (legal) begin
         expQ.push_back('{mPtr, w});
         mPtr = (mPtr + 1) % DEPTH;
         mCount++;
         if (mPtr == 0) mFull = 1;
      end else begin
         mErr = 1;
      end
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      checkOutput("count", 64'(count), 64'(mCount));
      checkOutput("full", 64'(full), 64'(mFull));
      checkOutput("err", 64'(err), 64'(mErr));
   endtask

   task automatic startPulse();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      mPtr = 0; mCount = 0; mFull = 0; mErr = 0;
      @(negedge clk);
      start = 1'b0;
      #1;
      checkOutput("start_count", 64'(count), 64'(0));
      checkOutput("start_full", 64'(full), 64'(0));
      checkOutput("start_err", 64'(err), 64'(0));
   endtask

   // Scoreboard monitor: every write strobe must match the oldest expected word.
   always @(negedge clk) begin
      expT e;
      if (imem_we === 1'b1) begin
         if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_write actual=addr %0d data %h required=no write", imem_addr, imem_wdata);
         end else begin
            e = expQ.pop_front();
            checkOutput("write_addr", 64'(imem_addr), 64'(e.addr));
            checkOutput("write_data", 64'(imem_wdata), 64'(e.data));
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reqT r;
      rst_n = 1'b0;
      start = 1'b0;
      bus.req_valid = 1'b0;
      driveReq(makeReq(5'd0, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 32'd0));
      bus.req_valid = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset_we", 64'(imem_we), 64'(0));
      checkOutput("reset_addr", 64'(imem_addr), 64'(0));
      checkOutput("reset_wdata", 64'(imem_wdata), 64'(0));
      checkOutput("reset_count", 64'(count), 64'(0));
      checkOutput("reset_full", 64'(full), 64'(0));
      checkOutput("reset_err", 64'(err), 64'(0));
      rst_n = 1'b1;
      #1 checkOutput("reset_ready", 64'(bus.req_ready), 64'(1));

      // addi x1,x0,5
      applyStimulus(makeReq(5'b00100, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5), 1, 32'h00500093, 0);
      // add x3,x1,x2 then sub x3,x1,x2
      applyStimulus(makeReq(5'b01100, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'd0), 1, 32'h002081B3, 0);
      applyStimulus(makeReq(5'b01100, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 32'd0), 1, 32'h402081B3, 0);
      // beq x1,x2,-8 fills the last address
      applyStimulus(makeReq(5'b11000, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'hFFFFFFF8), 1, 32'hFE208CE3, 0);
      startPulse();
      // lui x5,0x12345
      applyStimulus(makeReq(5'b01101, 5'd5, 5'd0, 5'd0, 3'd0, 1'b0, 32'h12345000), 1, 32'h123452B7, 0);

      // Illegal class: no write, err set; next legal request reuses the address.
      applyStimulus(makeReq(5'b11111, 5'd7, 5'd7, 5'd7, 3'd7, 1'b1, 32'hFFFFFFFF), 0, 32'd0, 0);
      applyStimulus(makeReq(5'b00100, 5'd2, 5'd1, 5'd0, 3'd0, 1'b0, 32'd1), 0, 32'd0, 0);
      startPulse();

      // Fill memory, then hold a request while full.
      for (int i = 0; i < DEPTH; i++) begin
         r = randReq();
         r.opc = 5'b01100;
         applyStimulus(r, 0, 32'd0, 0);
      end
      r = makeReq(5'b00100, 5'd9, 5'd8, 5'd0, 3'd0, 1'b0, 32'h7FF);
      @(negedge clk);
      driveReq(r);
      repeat (4) begin
         @(negedge clk);
         checkOutput("ready_when_full", 64'(bus.req_ready), 64'(0));
      end
      checkOutput("full_set", 64'(full), 64'(1));
      checkOutput("full_count", 64'(count), 64'(DEPTH));
      startPulse();
      applyStimulus(r, 0, 32'd0, 1);

      // start during FMT aborts the word.
      @(negedge clk);
      driveReq(makeReq(5'b01101, 5'd4, 5'd0, 5'd0, 3'd0, 1'b0, 32'hABCDE000));
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      mPtr = 0; mCount = 0; mFull = 0; mErr = 0;
      checkOutput("abort_fmt_we", 64'(imem_we), 64'(0));
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("abort_fmt_count", 64'(count), 64'(0));

      // Async reset in the WRITE cycle discards the write.
      @(negedge clk);
      driveReq(makeReq(5'b11011, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'h00000100));
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      @(posedge clk);
      #1 checkOutput("write_cycle_we", 64'(imem_we), 64'(1));
      rst_n = 1'b0;
      #1;
      checkOutput("rst_mid_we", 64'(imem_we), 64'(0));
      checkOutput("rst_mid_addr", 64'(imem_addr), 64'(0));
      checkOutput("rst_mid_wdata", 64'(imem_wdata), 64'(0));
      checkOutput("rst_mid_count", 64'(count), 64'(0));
      mPtr = 0; mCount = 0; mFull = 0; mErr = 0;
      @(negedge clk);
      rst_n = 1'b1;

      // Randomized program streams.
      for (int i = 0; i < 60; i++) begin
         if (mFull || $urandom_range(0, 9) == 0) startPulse();
         applyStimulus(randReq(), 0, 32'd0, 0);
      end

      repeat (4) @(negedge clk);
      checkOutput("scoreboard_empty", 64'(expQ.size()), 64'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
